// File: rtl/conv_sched_pkg.sv
// Shared types and widths for the conv_kernel_1x2_sched sequencer.
//   sched_state_e  : sequencer FSM states
//   WEIGHT_W       : one channel's 3x3 int4 weight window (9 x 4 bits)
//   IFM_WIN_W      : one 3x3 int4 input window
//   WEIGHT_PAIR_W  : weight memory word, {ch2, ch1}
package conv_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        WAIT_W,
        STREAM,
        DRAIN,
        NEXT,
        DONE
    } sched_state_e;

    localparam int WEIGHT_W      = 36;
    localparam int IFM_WIN_W     = 36;
    localparam int WEIGHT_PAIR_W = 2 * WEIGHT_W;

endpackage

// File: rtl/sched_valid_pipe.sv
// Fixed-latency tag line that follows the kernel's multiply/adder-tree pipe.
// Carries {valid, last, pair} STAGES cycles so the tags line up with the
// kernel's outputs.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/last/pair   : tags entering with the window transfer
//   out_valid/last/pair  : same tags, STAGES cycles later
module sched_valid_pipe #(
    parameter int STAGES = 4,
    parameter int PAIR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [PAIR_W-1:0] in_pair,
    output logic              out_valid,
    output logic              out_last,
    output logic [PAIR_W-1:0] out_pair
);

    localparam int W = PAIR_W + 2;

    logic [STAGES-1:0][W-1:0] vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= {in_valid, in_last, in_pair};
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign {out_valid, out_last, out_pair} = vld_pipe[STAGES-1];

endmodule

// File: rtl/conv_kernel_1x2_sched.sv
// Sequencer for the two-output-channel int4 3x3 convolution kernel.
// Per output-channel pair: read the pair's weights, hold them on the kernel
// weight inputs, replay one feature map of windows from the line buffer, and
// drain the kernel pipeline before moving to the next pair.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   start / busy / done          : layer controller handshake
//   weight_rd_en/addr/data       : weight memory, data one cycle after rd_en
//   weight_win3x3_ch1/ch2        : registered kernel weights
//   ifm_restart                  : pulse asking the line buffer to replay
//   win_valid / win_ready        : window handshake with the line buffer
//   ofm_valid / ofm_last / ofm_pair : kernel-output strobe and tags
//   perf_stall_cnt               : STREAM cycles starved of windows
//
// Build option: define SCHED_PERF_CNT_EN to build the stall counter;
// otherwise perf_stall_cnt is tied to zero.
module conv_kernel_1x2_sched
    import conv_sched_pkg::*;
#(
    parameter int WIN_NUM  = 676,
    parameter int OC_PAIRS = 4,
    parameter int PIPE_LAT = 4,
    parameter int WADDR_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     weight_rd_en,
    output logic [WADDR_W-1:0]       weight_rd_addr,
    input  logic [WEIGHT_PAIR_W-1:0] weight_rd_data,
    output logic [WEIGHT_W-1:0]      weight_win3x3_ch1,
    output logic [WEIGHT_W-1:0]      weight_win3x3_ch2,
    output logic                     ifm_restart,
    input  logic                     win_valid,
    output logic                     win_ready,
    output logic                     ofm_valid,
    output logic                     ofm_last,
    output logic [WADDR_W-1:0]       ofm_pair,
    output logic [31:0]              perf_stall_cnt
);

    localparam int WCNT_W = (WIN_NUM > 1) ? $clog2(WIN_NUM) : 1;
    localparam int DCNT_W = $clog2(PIPE_LAT + 1);

    localparam logic [WCNT_W-1:0]  WIN_LAST   = WCNT_W'(WIN_NUM - 1);
    localparam logic [DCNT_W-1:0]  DRAIN_LAST = DCNT_W'(PIPE_LAT - 1);
    localparam logic [WADDR_W-1:0] PAIR_LAST  = WADDR_W'(OC_PAIRS - 1);

    sched_state_e       state;
    logic [WCNT_W-1:0]  win_cnt;
    logic [DCNT_W-1:0]  drain_cnt;
    logic [WADDR_W-1:0] pair;

    logic xfer;
    logic xfer_last;

    // win_ready is a register that is high exactly in STREAM, so it doubles
    // as the state qualifier for the transfer.
    assign xfer           = win_valid && win_ready;
    assign xfer_last      = xfer && (win_cnt == WIN_LAST);
    assign weight_rd_addr = pair;

    // Outputs are registered on the transition into the state that owns
    // them, so each one is valid for exactly the cycles spent in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            pair              <= '0;
            win_cnt           <= '0;
            drain_cnt         <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            weight_rd_en      <= 1'b0;
            ifm_restart       <= 1'b0;
            win_ready         <= 1'b0;
            weight_win3x3_ch1 <= '0;
            weight_win3x3_ch2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LOAD_W;
                        pair         <= '0;
                        busy         <= 1'b1;
                        weight_rd_en <= 1'b1;
                    end
                end
                LOAD_W: begin
                    state        <= WAIT_W;
                    weight_rd_en <= 1'b0;
                    ifm_restart  <= 1'b1;
                end
                WAIT_W: begin
                    // Only place the kernel weights change.
                    {weight_win3x3_ch2, weight_win3x3_ch1} <= weight_rd_data;
                    ifm_restart <= 1'b0;
                    win_ready   <= 1'b1;
                    win_cnt     <= '0;
                    state       <= STREAM;
                end
                STREAM: begin
                    if (xfer) begin
                        win_cnt <= win_cnt + 1'b1;
                        if (xfer_last) begin
                            win_ready <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Hold the weights until the last window leaves the kernel.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= NEXT;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (pair == PAIR_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        pair         <= pair + 1'b1;
                        weight_rd_en <= 1'b1;
                        state        <= LOAD_W;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    sched_valid_pipe #(
        .STAGES (PIPE_LAT),
        .PAIR_W (WADDR_W)
    ) u_valid_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (xfer),
        .in_last   (xfer_last),
        .in_pair   (pair),
        .out_valid (ofm_valid),
        .out_last  (ofm_last),
        .out_pair  (ofm_pair)
    );

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == STREAM && !win_valid && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
